div_iter: RTL and testbench

- Parametrised, multi-cycle radix-2 restoring divider for the openMIPS execute stage.
- Computes quotient and remainder, signed or unsigned, of two WIDTH-bit operands.
- Results go to HI (remainder) and LO (quotient).
- Generalises the fixed 32-bit divider: configurable width, abort (annul) path, explicit divide-by-zero flag, busy indication.

---
 rtl/div_iter_if.sv | 23 ++
 rtl/div_iter.sv | 74 +++++++
 tb/tb_div_iter.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/div_iter_if.sv
// div_iter_if: request/result bundle between the EX stage and the iterative divider
// master: EX stage drives operands, start_i and annul_i; samples result_o, ready_o, busy_o and div_zero_o
// slave: divider side of the same signals
`timescale 1ns/1ps
interface div_iter_if #(parameter int WIDTH = 32);
    logic               signed_div_i;
    logic [WIDTH-1:0]   opdata1_i;
    logic [WIDTH-1:0]   opdata2_i;
    logic               start_i;
    logic               annul_i;
    logic [2*WIDTH-1:0] result_o;
    logic               ready_o;
    logic               busy_o;
    logic               div_zero_o;
    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o, busy_o, div_zero_o
    );
    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o, busy_o, div_zero_o
    );
endinterface

// File: rtl/div_iter.sv
// div_iter: multi-cycle radix-2 restoring divider, signed/unsigned, result_o = {remainder, quotient}
// ports: clk, rst (sync, active-high), d (div_iter_if.slave: operands, start/annul in; result/ready/busy/div_zero out)
`timescale 1ns/1ps
module div_iter #(parameter int WIDTH = 32) (
    input logic      clk,
    input logic      rst,
    div_iter_if.slave d
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {FREE, BY_ZERO, ON, END} state_t;
    state_t           state, state_n;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem, quo, dvs, q_fix, r_fix;
    logic             neg_q, neg_r, accept;
    logic [WIDTH:0]   trial;
    assign accept   = d.start_i && !d.annul_i;
    // partial remainder stays below the divisor, so bit WIDTH of the trial is the borrow
    assign trial    = {rem, quo[WIDTH-1]} - {1'b0, dvs};
    assign q_fix    = neg_q ? -quo : quo;
    assign r_fix    = neg_r ? -rem : rem;
    assign d.busy_o = (state == BY_ZERO) || (state == ON);
    always_comb begin
        state_n = state;
        unique case (state)
            FREE:    state_n = !accept ? FREE : (d.opdata2_i == '0) ? BY_ZERO : ON;
            // zero divisor waits one extra cycle so its result appears two edges after acceptance
            BY_ZERO: state_n = d.annul_i ? FREE : (cnt == '0) ? BY_ZERO : END;
            ON:      state_n = d.annul_i ? FREE : (cnt == CNT_W'(WIDTH)) ? END : ON;
            END:     state_n = (d.annul_i || !d.start_i) ? FREE : END;
            default: state_n = FREE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= FREE;
            cnt          <= '0;
            rem          <= '0;
            quo          <= '0;
            dvs          <= '0;
            neg_q        <= 1'b0;
            neg_r        <= 1'b0;
            d.result_o   <= '0;
            d.ready_o    <= 1'b0;
            d.div_zero_o <= 1'b0;
        end else begin
            state <= state_n;
            if (state == FREE && state_n != FREE) begin
                cnt   <= '0;
                rem   <= '0;
                quo   <= (d.signed_div_i && d.opdata1_i[WIDTH-1]) ? -d.opdata1_i : d.opdata1_i;
                dvs   <= (d.signed_div_i && d.opdata2_i[WIDTH-1]) ? -d.opdata2_i : d.opdata2_i;
                neg_q <= d.signed_div_i && (d.opdata1_i[WIDTH-1] ^ d.opdata2_i[WIDTH-1]);
                neg_r <= d.signed_div_i && d.opdata1_i[WIDTH-1];
            end
            if (state == BY_ZERO && state_n == BY_ZERO)
                cnt <= cnt + CNT_W'(1);
            if (state == ON && state_n == ON) begin
                cnt <= cnt + CNT_W'(1);
                rem <= trial[WIDTH] ? {rem[WIDTH-2:0], quo[WIDTH-1]} : trial[WIDTH-1:0];
                quo <= {quo[WIDTH-2:0], ~trial[WIDTH]};
            end
            if (state_n == END && state != END) begin
                d.ready_o    <= 1'b1;
                d.div_zero_o <= (state == BY_ZERO);
                d.result_o   <= (state == ON) ? {r_fix, q_fix} : '0;
            end
            if (state_n == FREE) begin
                d.result_o   <= '0;
                d.ready_o    <= 1'b0;
                d.div_zero_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: directed self-checking bench for div_iter at WIDTH=32 and WIDTH=8
`timescale 1ns/1ps
module tb_div_iter;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;
    int   ones;
    div_iter_if #(.WIDTH(32)) b32 ();
    div_iter_if #(.WIDTH(8))  b8 ();
    div_iter #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .d(b32.slave));
    div_iter #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .d(b8.slave));
    always #5 clk = ~clk;
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic go32(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int lat);
        int n;
        b32.signed_div_i = s;
        b32.opdata1_i    = a;
        b32.opdata2_i    = b;
        b32.start_i      = 1'b1;
        step;
        b32.opdata1_i    = ~a;
        b32.opdata2_i    = 32'h0;
        b32.signed_div_i = ~s;
        n = 0;
        while (!b32.ready_o && n < 40) begin
            step;
            n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'(lat));
        chk({tag, "_res"}, b32.result_o, exp);
        chk({tag, "_dz"}, 64'(b32.div_zero_o), 64'(b == 32'h0));
        b32.start_i = 1'b0;
        step;
        chk({tag, "_drop"}, 64'(b32.ready_o), 64'(0));
        step;
    endtask
    task automatic go8(input string tag, input logic s, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] exp, input int lat);
        int n;
        b8.signed_div_i = s;
        b8.opdata1_i    = a;
        b8.opdata2_i    = b;
        b8.start_i      = 1'b1;
        step;
        b8.opdata1_i    = ~a;
        b8.opdata2_i    = 8'h0;
        n = 0;
        while (!b8.ready_o && n < 20) begin
            step;
            n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'(lat));
        chk({tag, "_res"}, 64'(b8.result_o), 64'(exp));
        chk({tag, "_dz"}, 64'(b8.div_zero_o), 64'(b == 8'h0));
        b8.start_i = 1'b0;
        step;
        step;
    endtask
    initial begin
        rst = 1'b1;
        b32.signed_div_i = 1'b0; b32.opdata1_i = '0; b32.opdata2_i = '0; b32.start_i = 1'b0; b32.annul_i = 1'b0;
        b8.signed_div_i  = 1'b0; b8.opdata1_i  = '0; b8.opdata2_i  = '0; b8.start_i  = 1'b0; b8.annul_i  = 1'b0;
        step;
        step;
        chk("rst_res32", b32.result_o, 64'h0);
        chk("rst_rdy32", 64'(b32.ready_o), 64'(0));
        chk("rst_busy32", 64'(b32.busy_o), 64'(0));
        chk("rst_dz32", 64'(b32.div_zero_o), 64'(0));
        chk("rst_res8", 64'(b8.result_o), 64'h0);
        rst = 1'b0;
        step;
        chk("idle_busy", 64'(b32.busy_o), 64'(0));
        // 100 / 7 with cycle-by-cycle busy/ready observation
        b32.opdata1_i = 32'd100;
        b32.opdata2_i = 32'd7;
        b32.start_i   = 1'b1;
        step;
        chk("t1_busy_e0", 64'(b32.busy_o), 64'(1));
        ones = 0;
        repeat (32) begin
            step;
            ones += int'(b32.busy_o);
        end
        chk("t1_busy_run", 64'(ones), 64'(32));
        chk("t1_rdy_e32", 64'(b32.ready_o), 64'(0));
        step;
        chk("t1_rdy", 64'(b32.ready_o), 64'(1));
        chk("t1_busy_end", 64'(b32.busy_o), 64'(0));
        chk("t1_res", b32.result_o, 64'h00000002_0000000E);
        chk("t1_dz", 64'(b32.div_zero_o), 64'(0));
        step;
        chk("t1_hold_rdy", 64'(b32.ready_o), 64'(1));
        chk("t1_hold_res", b32.result_o, 64'h00000002_0000000E);
        b32.start_i = 1'b0;
        step;
        chk("t1_drop_rdy", 64'(b32.ready_o), 64'(0));
        chk("t1_drop_res", b32.result_o, 64'h0);
        step;
        go32("t2a", 1'b1, 32'hFFFFFFFB, 32'h00000006, 64'hFFFFFFFB_00000000, 33);
        go32("t2b", 1'b1, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 33);
        go32("t2c", 1'b0, 32'hFFFFFFFB, 32'h00000006, 64'h00000005_2AAAAAA9, 33);
        go32("t2d", 1'b1, 32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33);
        go32("t2e", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 64'hFFFFFFFE_0000000E, 33);
        go32("t3", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33);
        go32("t4", 1'b0, 32'h00001234, 32'h00000000, 64'h0, 2);
        // annul on the 10th ON cycle
        b32.signed_div_i = 1'b0;
        b32.opdata1_i    = 32'd1000;
        b32.opdata2_i    = 32'd3;
        b32.start_i      = 1'b1;
        step;
        repeat (9) step;
        b32.annul_i = 1'b1;
        b32.start_i = 1'b0;
        step;
        chk("t5_annul_rdy", 64'(b32.ready_o), 64'(0));
        chk("t5_annul_busy", 64'(b32.busy_o), 64'(0));
        b32.annul_i = 1'b0;
        step;
        chk("t5_stay_free", 64'(b32.busy_o), 64'(0));
        go32("t5b", 1'b0, 32'd50, 32'd5, 64'h00000000_0000000A, 33);
        // annul in FREE blocks acceptance
        b32.opdata1_i = 32'd100;
        b32.opdata2_i = 32'd7;
        b32.annul_i   = 1'b1;
        b32.start_i   = 1'b1;
        step;
        step;
        chk("t5_annul_free", 64'(b32.busy_o), 64'(0));
        b32.annul_i = 1'b0;
        b32.start_i = 1'b0;
        step;
        // reset mid-ON
        b32.opdata1_i = 32'd1000;
        b32.opdata2_i = 32'd3;
        b32.start_i   = 1'b1;
        step;
        repeat (5) step;
        rst = 1'b1;
        step;
        chk("t5_rst_busy", 64'(b32.busy_o), 64'(0));
        chk("t5_rst_rdy", 64'(b32.ready_o), 64'(0));
        chk("t5_rst_res", b32.result_o, 64'h0);
        rst = 1'b0;
        b32.start_i = 1'b0;
        step;
        // annul while holding a result in END
        b32.opdata1_i = 32'd100;
        b32.opdata2_i = 32'd7;
        b32.start_i   = 1'b1;
        repeat (34) step;
        chk("t5_end_rdy", 64'(b32.ready_o), 64'(1));
        b32.annul_i = 1'b1;
        step;
        chk("t5_end_annul_rdy", 64'(b32.ready_o), 64'(0));
        chk("t5_end_annul_res", b32.result_o, 64'h0);
        b32.annul_i = 1'b0;
        b32.start_i = 1'b0;
        step;
        // reset while a divide-by-zero result is held
        b32.opdata1_i = 32'h1234;
        b32.opdata2_i = 32'h0;
        b32.start_i   = 1'b1;
        step;
        chk("t4_busy_bz", 64'(b32.busy_o), 64'(1));
        step;
        step;
        chk("t4_dz_set", 64'(b32.div_zero_o), 64'(1));
        rst = 1'b1;
        step;
        chk("t4_rst_dz", 64'(b32.div_zero_o), 64'(0));
        chk("t4_rst_rdy", 64'(b32.ready_o), 64'(0));
        rst = 1'b0;
        b32.start_i = 1'b0;
        step;
        go8("t6a", 1'b1, 8'hFB, 8'h06, 16'hFB00, 9);
        go8("t6b", 1'b0, 8'hFF, 8'h10, 16'h0F0F, 9);
        go8("t6c", 1'b1, 8'h80, 8'hFF, 16'h0080, 9);
        go8("t6d", 1'b0, 8'h37, 8'h00, 16'h0000, 2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
